// File: rtl/iitk_mini_mips_pkg.sv
// Shared constants and types for the iitk_mini_mips core:
// opcode/funct encodings, ALU operations and write-back select.
package iitk_mini_mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_MUL,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_LINK
    } wb_sel_e;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: two operands, operation and shift amount
// in; result and zero flag out. All arithmetic wraps mod 2^32.
module mips_alu
    import iitk_mini_mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    // Operation select; shifts act on b (the rt operand)
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLL: result_o = b_i << shamt_i;
            ALU_SRL: result_o = b_i >> shamt_i;
            ALU_MUL: result_o = a_i * b_i;
            ALU_LUI: result_o = {b_i[15:0], 16'h0000};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/iitk_mini_mips.sv
// Single-cycle MIPS-subset core with loadable instruction memory,
// data memory, register file, decode and PC logic.
module iitk_mini_mips
    import iitk_mini_mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 4096,
    parameter int          DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_mode,
    input  logic        write_enable,
    input  logic [11:0] init_address,
    input  logic [31:0] init_instruction,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic [31:0] debug_result
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rf_q [32];

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] dbg_q;

    logic [IW-1:0] if_idx;
    logic [31:0]   instr;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [31:0]   sext;
    logic [31:0]   zext;
    logic [31:0]   pc4;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;

    alu_op_e     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        rf_we;
    logic [4:0]  rf_dst;
    wb_sel_e     wb_sel;
    logic        dm_we;
    logic [31:0] wb_val;
    logic [DW-1:0] dm_idx;
    logic [31:0] dm_rdata;

    assign if_idx = IW'((pc_q - RESET_PC) >> 2);
    assign instr  = imem[if_idx];
    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign sext   = {{16{instr[15]}}, instr[15:0]};
    assign zext   = {16'h0000, instr[15:0]};
    assign pc4    = pc_q + 32'd4;
    assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

    mips_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b),
        .shamt_i  (shamt),
        .op_i     (alu_op),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign dm_idx   = DW'(alu_res >> 2);
    assign dm_rdata = dmem[dm_idx];

    // Decode: operand select, write-back control and next PC
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rt_val;
        rf_we  = 1'b0;
        rf_dst = rd;
        wb_sel = WB_ALU;
        dm_we  = 1'b0;
        pc_d   = pc4;
        case (op)
            OP_RTYPE: begin
                rf_we = 1'b1;
                case (funct)
                    F_ADD: alu_op = ALU_ADD;
                    F_SUB: alu_op = ALU_SUB;
                    F_AND: alu_op = ALU_AND;
                    F_OR:  alu_op = ALU_OR;
                    F_XOR: alu_op = ALU_XOR;
                    F_NOR: alu_op = ALU_NOR;
                    F_SLT: alu_op = ALU_SLT;
                    F_SLL: alu_op = ALU_SLL;
                    F_SRL: alu_op = ALU_SRL;
                    F_MUL: alu_op = ALU_MUL;
                    F_JR: begin
                        rf_we = 1'b0;
                        pc_d  = rs_val;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI: begin
                rf_we  = 1'b1;
                rf_dst = rt;
                alu_b  = zext;
                case (op)
                    OP_ADDI: begin
                        alu_op = ALU_ADD;
                        alu_b  = sext;
                    end
                    OP_SLTI: begin
                        alu_op = ALU_SLT;
                        alu_b  = sext;
                    end
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    default: alu_op = ALU_LUI;
                endcase
            end
            OP_LW: begin
                alu_b  = sext;
                rf_we  = 1'b1;
                rf_dst = rt;
                wb_sel = WB_MEM;
            end
            OP_SW: begin
                alu_b = sext;
                dm_we = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB;
                if (alu_zero == (op == OP_BEQ))
                    pc_d = pc4 + {sext[29:0], 2'b00};
            end
            OP_J: pc_d = {pc4[31:28], instr[25:0], 2'b00};
            OP_JAL: begin
                pc_d   = {pc4[31:28], instr[25:0], 2'b00};
                rf_we  = 1'b1;
                rf_dst = 5'd31;
                wb_sel = WB_LINK;
            end
            default: ;
        endcase
    end

    // Write-back value mux
    always_comb begin
        wb_val = alu_res;
        case (wb_sel)
            WB_MEM:  wb_val = dm_rdata;
            WB_LINK: wb_val = pc4;
            default: wb_val = alu_res;
        endcase
    end

    // Instruction load port; independent of reset so loading can
    // overlap the reset phase
    always_ff @(posedge clk) begin
        if (init_mode && write_enable)
            imem[IW'(init_address)] <= init_instruction;
    end

    // Data memory store, only while executing
    always_ff @(posedge clk) begin
        if (reset && !init_mode && dm_we)
            dmem[dm_idx] <= rt_val;
    end

    // Architectural state commit; frozen during load phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            dbg_q <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else if (!init_mode) begin
            pc_q <= pc_d;
            if (rf_we && rf_dst != 5'd0) begin
                rf_q[rf_dst] <= wb_val;
                dbg_q        <= wb_val;
            end
        end
    end

    assign pc_out          = pc_q;
    assign instruction_out = instr;
    assign debug_result    = dbg_q;

endmodule

// File: tb/tb_iitk_mini_mips.sv
// Scoreboard bench for iitk_mini_mips: stimulus queues expected
// PC/debug pairs, a negedge monitor pops and compares them.
module tb_iitk_mini_mips;

    localparam logic [31:0] B = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_mode;
    logic        write_enable;
    logic [11:0] init_address;
    logic [31:0] init_instruction;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic [31:0] debug_result;

    iitk_mini_mips dut (
        .clk              (clk),
        .reset            (reset),
        .init_mode        (init_mode),
        .write_enable     (write_enable),
        .init_address     (init_address),
        .init_instruction (init_instruction),
        .pc_out           (pc_out),
        .instruction_out  (instruction_out),
        .debug_result     (debug_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] dbg;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic        mon_en = 1'b0;
    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] prog [32];

    task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", n, act, exp);
        end
    endtask

    task automatic expect_st(string n, logic [31:0] p, logic [31:0] d);
        exp_t e;
        e.name = n;
        e.pc   = p;
        e.dbg  = d;
        sbq.push_back(e);
    endtask

    // Monitor: one scoreboard entry per observed cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got pc %08h expected none",
                         pc_out);
            end else begin
                mon_e = sbq.pop_front();
                cmp({mon_e.name, "_pc"}, pc_out, mon_e.pc);
                cmp({mon_e.name, "_dbg"}, debug_result, mon_e.dbg);
            end
        end
    end

    // Observe n cycles with init_mode=im; called at negedge+1
    task automatic window(int n, logic im);
        init_mode = im;
        mon_en    = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        mon_en    = 1'b0;
        init_mode = 1'b1;
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_left: got %0d entries expected 0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    endtask

    // Load 32 words with reset held low, then release reset frozen
    task automatic load_prog();
        reset     = 1'b0;
        init_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            write_enable     = 1'b1;
            init_address     = 12'(i);
            init_instruction = prog[i];
            @(negedge clk);
            #1;
        end
        write_enable = 1'b0;
        reset        = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        init_mode        = 1'b1;
        write_enable     = 1'b0;
        init_address     = '0;
        init_instruction = '0;
        @(negedge clk);
        #1;

        // addi/addi/mul
        clr_prog();
        prog[0] = 32'h2008_0006;
        prog[1] = 32'h2009_0007;
        prog[2] = 32'h0109_5018;
        load_prog();
        expect_st("rst_state", B, 32'h0);
        window(1, 1'b1);
        expect_st("mul_a", B + 4, 32'd6);
        expect_st("mul_b", B + 8, 32'd7);
        expect_st("mul_c", B + 12, 32'd42);
        expect_st("mul_nop", B + 16, 32'd42);
        window(4, 1'b0);
        expect_st("freeze_a", B + 16, 32'd42);
        expect_st("freeze_b", B + 16, 32'd42);
        window(2, 1'b1);

        // asynchronous reset mid-cycle
        init_mode = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmp("async_rst_pc", pc_out, B);
        cmp("async_rst_dbg", debug_result, 32'h0);
        @(negedge clk);
        #1;
        expect_st("rst_hold_a", B, 32'h0);
        expect_st("rst_hold_b", B, 32'h0);
        window(2, 1'b0);
        reset = 1'b1;
        expect_st("rerun_a", B + 4, 32'd6);
        expect_st("rerun_b", B + 8, 32'd7);
        expect_st("rerun_c", B + 12, 32'd42);
        window(3, 1'b0);

        // addi -5, slt, sub, sll
        clr_prog();
        prog[0] = 32'h2008_FFFB;
        prog[1] = 32'h0100_482A;
        prog[2] = 32'h0008_5022;
        prog[3] = 32'h000A_5900;
        load_prog();
        expect_st("neg_addi", B + 4, 32'hFFFF_FFFB);
        expect_st("slt", B + 8, 32'd1);
        expect_st("sub", B + 12, 32'd5);
        expect_st("sll", B + 16, 32'h50);
        window(4, 1'b0);

        // regs cleared, sw/lw, $0 writes
        clr_prog();
        prog[0] = 32'h210B_0003;
        prog[1] = 32'h2008_0055;
        prog[2] = 32'hAC08_0008;
        prog[3] = 32'h200A_0001;
        prog[4] = 32'h8C09_0008;
        prog[5] = 32'h0129_6020;
        prog[6] = 32'h2000_0009;
        prog[7] = 32'h000C_6825;
        load_prog();
        expect_st("rf_cleared", B + 4, 32'd3);
        expect_st("addi_55", B + 8, 32'h55);
        expect_st("sw_hold", B + 12, 32'h55);
        expect_st("addi_1", B + 16, 32'd1);
        expect_st("lw", B + 20, 32'h55);
        expect_st("add_lw", B + 24, 32'hAA);
        expect_st("wr_r0", B + 28, 32'hAA);
        expect_st("rd_r0", B + 32, 32'hAA);
        window(8, 1'b0);

        // beq/bne/jal/jr
        clr_prog();
        prog[0] = 32'h1000_0002;
        prog[1] = 32'h2008_0063;
        prog[2] = 32'h2008_0063;
        prog[3] = 32'h1400_0005;
        prog[4] = 32'h0C10_0008;
        prog[5] = 32'h2008_0012;
        prog[8] = 32'h03E0_0008;
        load_prog();
        expect_st("beq", B + 12, 32'h0);
        expect_st("bne", B + 16, 32'h0);
        expect_st("jal", B + 32, B + 20);
        expect_st("jr", B + 20, B + 20);
        expect_st("after_jr", B + 24, 32'h12);
        window(5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iitk_mini_mips.md
Name: iitk_mini_mips

Overview:
- Single-cycle 32-bit MIPS-subset processor with an on-chip instruction memory and data memory.
- Instruction memory is loaded through a word-addressed init port while execution is held off.
- Execution then runs one instruction per clock starting at 0x00400000.
- Exposes PC, current instruction and last write-back value for debug and benches.

Parameters:
- RESET_PC, 32'h00400000, PC value after reset.
- IMEM_DEPTH, 4096, instruction memory words (12-bit word index).
- DMEM_DEPTH, 1024, data memory words.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset.
- init_mode  input  1  1 = load phase, execution frozen.
- write_enable  input  1  instruction-memory write strobe (effective only when init_mode=1).
- init_address  input  12  instruction-memory word index for loading.
- init_instruction  input  32  instruction word to load.
- pc_out  output  32  current PC.
- instruction_out  output  32  instruction at current PC (combinational).
- debug_result  output  32  value most recently written to the register file.

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC.
  - All 32 registers = 0.
  - debug_result = 0.
  - Data memory is not cleared.
  - Instruction memory is not cleared.
- Init writes:
  - On posedge clk with init_mode=1 and write_enable=1, imem[init_address] <= init_instruction.
  - Writes happen regardless of reset level, so loading proceeds while reset is asserted.
  - Unwritten imem words power up as 0 (nop).
- Freeze: while reset=0 or init_mode=1, no PC, register, data-memory or debug_result update.
- Fetch:
  - index = (pc_out - RESET_PC)[13:2].
  - instruction_out = imem[index], combinational.
  - An index beyond depth wraps modulo 4096.
- Execute:
  - One instruction per cycle; all state commits on the posedge clk.
  - Default next PC = PC+4.
- R-type (opcode 000000), funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt (signed)
  - 000000 sll rt by shamt
  - 000010 srl rt by shamt
  - 011000 mul: rd <= low 32 bits of rs*rt (signed); no HI/LO registers.
  - 001000 jr: PC <= rs.
- I-type:
  - 001000 addi: sign-extended immediate.
  - 001100 andi, 001101 ori, 001110 xori: zero-extended immediate.
  - 001010 slti: signed compare.
  - 001111 lui.
  - 100011 lw / 101011 sw: address rs+sext(imm); word index = addr[11:2].
  - 000100 beq / 000101 bne: target PC+4+(sext(imm)<<2).
- J-type:
  - 000010 j: PC <= {PC+4[31:28], target, 2'b00}.
  - 000011 jal: same target, $31 <= PC+4.
- Arithmetic:
  - All arithmetic wraps modulo 2^32.
  - No overflow exceptions.
- Registers:
  - Two async read ports, one sync write port.
  - Writes to $0 are discarded; $0 always reads 0.
- debug_result: on every cycle with a register write to a nonzero destination, loads the written value. Otherwise it holds.
- Unknown opcode or funct: treated as nop; PC+4, no state change.

Decomposition:
- Shared package holds opcode and funct constants, ALU-op enum and RESET_PC.
- One natural sub-module: mips_alu (combinational; operands, alu op, shamt -> result, zero flag).
- Register file, memories, decode and PC logic stay in the top.

Test Plan:
- Load addi $t0,$0,6; addi $t1,$0,7; mul $t2,$t0,$t1 (0x01095018) with reset=0 and init_mode=1, then release -> pc_out steps 0x00400000, 04, 08, 0C; debug_result=42 when pc_out=0x0040000C.
- Pulse reset low mid-run -> pc_out=0x00400000 and debug_result=0 immediately (asynchronous), registers cleared, imem contents intact.
- addi $t0,$0,-5; slt $t1,$t0,$0; sub $t2,$0,$t0 -> debug_result 0xFFFFFFFB, then 1, then 5.
- addi $t0,$0,0x55; sw $t0,8($0); lw $t1,8($0) -> debug_result=0x55 after lw.
- beq $0,$0,+2 at 0x00400000 -> next pc_out=0x0040000C; bne $0,$0 -> falls through to PC+4.
- addi $0,$0,9 -> $0 still reads 0, debug_result unchanged; init_mode=1 during run -> PC frozen.
